// File: rtl/shared_mem_arb_if.sv
// ---------------------------------------------------------------------------
// shared_mem_arb_if
//   One requester port of the shared memory arbiter.
//   master modport : the requester (drives req/we/addr/wdata)
//   slave  modport : the memory (drives gnt/rvalid/rdata/err)
//   req    : access request, held until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address
//   wdata  : write data
//   gnt    : request accepted this cycle (combinational)
//   rvalid : read data valid, one-cycle pulse the cycle after a read grant
//   rdata  : registered read data, holds while rvalid = 0
//   err    : out-of-range access, one-cycle pulse the cycle after the grant
// ---------------------------------------------------------------------------
interface shared_mem_arb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/shared_mem_arb.sv
// ---------------------------------------------------------------------------
// shared_mem_arb
//   Single-array data memory shared by two requesters (A: core datapath,
//   B: host/loader) behind a built-in arbiter. One access per cycle, read
//   data registered with a valid strobe, out-of-range error pulse, a
//   hardware clear engine and the low TAPS words exported for debug.
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   a_if      : requester A (slave side of shared_mem_arb_if)
//   b_if      : requester B (slave side of shared_mem_arb_if)
//   clr_start : pulse, zero the whole array (wins over requests in IDLE)
//   clr_busy  : clear engine running (exactly DEPTH cycles)
//   taps      : word i on bits [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module shared_mem_arb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 42,
  parameter int TAPS     = 4,
  parameter int ARB_MODE = 0   // 0: fixed priority A over B, 1: round-robin
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shared_mem_arb_if.slave        a_if,
  shared_mem_arb_if.slave        b_if,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic [TAPS*DATA_W-1:0] taps
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
  // One bit wider so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_rr_prefer_b;   // 1: B wins the next contention (RR only)

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_clr_we;

  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_word;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_a_rvalid;
  logic              r_a_err;
  logic [DATA_W-1:0] r_a_rdata;
  logic              r_b_rvalid;
  logic              r_b_err;
  logic [DATA_W-1:0] r_b_rdata;

  // -------------------------------------------------------------------------
  // Next-state / grant logic
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_a_gnt      = 1'b0;
    w_b_gnt      = 1'b0;
    w_clr_we     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A clear request takes the cycle; pending requests simply wait.
        if (clr_start) begin
          w_next_state = ST_CLEAR;
        end else if (a_if.req && b_if.req) begin
          if (ARB_MODE == 1 && r_rr_prefer_b) w_b_gnt = 1'b1;
          else                                w_a_gnt = 1'b1;
        end else if (a_if.req) begin
          w_a_gnt = 1'b1;
        end else if (b_if.req) begin
          w_b_gnt = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_cnt == CNT_LAST) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, clear counter and round-robin pointer
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_clr_cnt     <= '0;
      r_rr_prefer_b <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Counter stays at 0 outside CLEAR so the next clear starts at word 0.
      if (r_state == ST_CLEAR && w_next_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                                                 r_clr_cnt <= '0;
      // Pointer tracks the last granted port; only consulted in round-robin.
      if (w_a_gnt)      r_rr_prefer_b <= 1'b1;
      else if (w_b_gnt) r_rr_prefer_b <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Selected access
  // -------------------------------------------------------------------------
  assign w_sel_we    = w_b_gnt ? b_if.we    : a_if.we;
  assign w_sel_addr  = w_b_gnt ? b_if.addr  : a_if.addr;
  assign w_sel_wdata = w_b_gnt ? b_if.wdata : a_if.wdata;
  assign w_in_range  = ({1'b0, w_sel_addr} < DEPTH_EXT);
  assign w_rd_word   = w_in_range ? r_mem[w_sel_addr] : '0;

  // NOTE: the array has no reset; contents survive rst_n and only the clear
  // engine (or writes) zero them, which also keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if ((w_a_gnt || w_b_gnt) && w_sel_we && w_in_range) begin
      r_mem[w_sel_addr] <= w_sel_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Per-port response registers: only the granted port sees rvalid/err.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rvalid <= 1'b0;
      r_b_err    <= 1'b0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_a_gnt && !a_if.we;
      r_a_err    <= w_a_gnt && !w_in_range;
      if (w_a_gnt && !a_if.we) r_a_rdata <= w_rd_word;
      r_b_rvalid <= w_b_gnt && !b_if.we;
      r_b_err    <= w_b_gnt && !w_in_range;
      if (w_b_gnt && !b_if.we) r_b_rdata <= w_rd_word;
    end
  end

  assign a_if.gnt    = w_a_gnt;
  assign a_if.rvalid = r_a_rvalid;
  assign a_if.rdata  = r_a_rdata;
  assign a_if.err    = r_a_err;
  assign b_if.gnt    = w_b_gnt;
  assign b_if.rvalid = r_b_rvalid;
  assign b_if.rdata  = r_b_rdata;
  assign b_if.err    = r_b_err;

  assign clr_busy = (r_state == ST_CLEAR);

  for (genvar i = 0; i < TAPS; i++) begin : g_taps
    assign taps[i*DATA_W +: DATA_W] = r_mem[i];
  end

endmodule

// File: tb/tb_shared_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_shared_mem_arb
//   Two instances share clock, reset and clr_start: dut0 fixed priority,
//   dut1 round-robin. Each requester port has a job queue served by a
//   driver that holds req until gnt. A reference model (plain array,
//   remaining-clear counter, last-granted flag) predicts every output and a
//   compare process checks them on each falling edge. Directed literal
//   checks pin grant orders, read values and clear timing.
// ---------------------------------------------------------------------------
module tb_shared_mem_arb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 42;
  localparam int TAPS   = 4;
  localparam int RR_DUT = 1;   // dut1 runs round-robin arbitration

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n     = 1'b0;
  logic clr_start = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Port k = 2*dut + port (port 0 = A, 1 = B)
  logic              t_req   [4] = '{default: 1'b0};
  logic              t_we    [4] = '{default: 1'b0};
  logic [ADDR_W-1:0] t_addr  [4] = '{default: '0};
  logic [DATA_W-1:0] t_wdata [4] = '{default: '0};
  logic              t_gnt   [4];
  logic              t_rv    [4];
  logic              t_err   [4];
  logic [DATA_W-1:0] t_rd    [4];
  logic              t_busy  [2];
  logic [TAPS*DATA_W-1:0] t_taps [2];

  job_t jq [4][$];

  shared_mem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a0 ();
  shared_mem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b0 ();
  shared_mem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a1 ();
  shared_mem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b1 ();

  assign if_a0.req = t_req[0]; assign if_a0.we = t_we[0]; assign if_a0.addr = t_addr[0]; assign if_a0.wdata = t_wdata[0];
  assign if_b0.req = t_req[1]; assign if_b0.we = t_we[1]; assign if_b0.addr = t_addr[1]; assign if_b0.wdata = t_wdata[1];
  assign if_a1.req = t_req[2]; assign if_a1.we = t_we[2]; assign if_a1.addr = t_addr[2]; assign if_a1.wdata = t_wdata[2];
  assign if_b1.req = t_req[3]; assign if_b1.we = t_we[3]; assign if_b1.addr = t_addr[3]; assign if_b1.wdata = t_wdata[3];

  assign t_gnt[0] = if_a0.gnt; assign t_rv[0] = if_a0.rvalid; assign t_rd[0] = if_a0.rdata; assign t_err[0] = if_a0.err;
  assign t_gnt[1] = if_b0.gnt; assign t_rv[1] = if_b0.rvalid; assign t_rd[1] = if_b0.rdata; assign t_err[1] = if_b0.err;
  assign t_gnt[2] = if_a1.gnt; assign t_rv[2] = if_a1.rvalid; assign t_rd[2] = if_a1.rdata; assign t_err[2] = if_a1.err;
  assign t_gnt[3] = if_b1.gnt; assign t_rv[3] = if_b1.rvalid; assign t_rd[3] = if_b1.rdata; assign t_err[3] = if_b1.err;

  shared_mem_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TAPS(TAPS), .ARB_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .a_if(if_a0), .b_if(if_b0),
    .clr_start(clr_start), .clr_busy(t_busy[0]), .taps(t_taps[0])
  );

  shared_mem_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TAPS(TAPS), .ARB_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .a_if(if_a1), .b_if(if_b1),
    .clr_start(clr_start), .clr_busy(t_busy[1]), .taps(t_taps[1])
  );

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] m_mem      [2][DEPTH];
  bit                m_known    [2][DEPTH] = '{default: '0};
  int                m_clr_left [2]        = '{default: 0};  // clear cycles still to run
  bit                m_last_a   [2]        = '{default: 1'b0};
  bit                m_rv       [4]        = '{default: 1'b0};
  bit                m_err      [4]        = '{default: 1'b0};
  logic [DATA_W-1:0] m_rd       [4]        = '{default: '0};
  bit                m_rd_known [4]        = '{default: 1'b1};

  // Observation logs kept by the compare process
  int                gq       [2][$];
  logic [DATA_W-1:0] last_rd  [4] = '{default: '0};
  int                err_cnt  [4] = '{default: 0};
  int                busy_cnt [2] = '{default: 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which port (0 = A, 1 = B) should be granted now; -1 for none.
  function automatic int exp_gnt(input int d);
    bit ra, rb;
    ra = t_req[2*d];
    rb = t_req[2*d+1];
    if (m_clr_left[d] > 0 || clr_start) return -1;
    if (ra && rb) return (d == RR_DUT && m_last_a[d]) ? 1 : 0;
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_clr_left[d] = 0;
        m_last_a[d]   = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        m_rv[k] = 1'b0; m_err[k] = 1'b0; m_rd[k] = '0; m_rd_known[k] = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int g;
        int k;
        g = exp_gnt(d);
        m_rv[2*d] = 1'b0; m_rv[2*d+1] = 1'b0;
        m_err[2*d] = 1'b0; m_err[2*d+1] = 1'b0;
        if (g >= 0) begin
          k = 2*d + g;
          if (int'(t_addr[k]) < DEPTH) begin
            if (t_we[k]) begin
              m_mem[d][t_addr[k]]   = t_wdata[k];
              m_known[d][t_addr[k]] = 1'b1;
            end else begin
              m_rv[k]       = 1'b1;
              m_rd[k]       = m_mem[d][t_addr[k]];
              m_rd_known[k] = m_known[d][t_addr[k]];
            end
          end else begin
            m_err[k] = 1'b1;
            if (!t_we[k]) begin
              m_rv[k] = 1'b1; m_rd[k] = '0; m_rd_known[k] = 1'b1;
            end
          end
          m_last_a[d] = (g == 0);
        end
        if (m_clr_left[d] > 0) begin
          m_mem[d][DEPTH - m_clr_left[d]]   = '0;
          m_known[d][DEPTH - m_clr_left[d]] = 1'b1;
          m_clr_left[d]--;
        end else if (clr_start) begin
          m_clr_left[d] = DEPTH;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Compare process (falling edge, away from the active edge)
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int g;
      g = exp_gnt(d);
      check($sformatf("d%0d clr_busy", d), 64'(t_busy[d]), 64'(m_clr_left[d] > 0));
      for (int w = 0; w < TAPS; w++)
        if (m_known[d][w])
          check($sformatf("d%0d taps[%0d]", d, w), 64'(t_taps[d][w*DATA_W +: DATA_W]), 64'(m_mem[d][w]));
      for (int p = 0; p < 2; p++) begin
        int k;
        k = 2*d + p;
        check($sformatf("d%0d p%0d gnt", d, p),    64'(t_gnt[k]), 64'(g == p));
        check($sformatf("d%0d p%0d rvalid", d, p), 64'(t_rv[k]),  64'(m_rv[k]));
        check($sformatf("d%0d p%0d err", d, p),    64'(t_err[k]), 64'(m_err[k]));
        if (m_rd_known[k])
          check($sformatf("d%0d p%0d rdata", d, p), 64'(t_rd[k]), 64'(m_rd[k]));
        if (t_gnt[k]) gq[d].push_back(p);
        if (t_rv[k])  last_rd[k] = t_rd[k];
        if (t_err[k]) err_cnt[k]++;
      end
      if (t_busy[d]) busy_cnt[d]++;
    end
  end

  // -------------------------------------------------------------------------
  // Requester drivers: hold req until gnt, back-to-back when jobs queued
  // -------------------------------------------------------------------------
  task automatic port_driver(input int k);
    logic g;
    job_t j;
    forever begin
      @(negedge clk);
      g = t_gnt[k];
      @(posedge clk);
      #1;
      if (g) t_req[k] = 1'b0;
      if (!t_req[k] && jq[k].size() != 0) begin
        j = jq[k].pop_front();
        t_we[k]    = j.we;
        t_addr[k]  = j.addr;
        t_wdata[k] = j.wdata;
        t_req[k]   = 1'b1;
      end
    end
  endtask

  // Same job on the same port of both instances.
  task automatic push(input int p, input logic we, input int addr, input logic [DATA_W-1:0] wdata);
    job_t j;
    j.we = we; j.addr = ADDR_W'(addr); j.wdata = wdata;
    jq[p].push_back(j);
    jq[2+p].push_back(j);
  endtask

  // Wait until all jobs are done and no clear is running; ends at posedge+2.
  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #2;
      done = 1'b1;
      for (int k = 0; k < 4; k++) if (t_req[k] || jq[k].size() != 0) done = 1'b0;
      for (int d = 0; d < 2; d++) if (m_clr_left[d] > 0) done = 1'b0;
    end
    check("idle_reached", 64'(done), 64'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  function automatic int seq_code(input int d, input int start);
    int v;
    v = 0;
    for (int i = start; i < gq[d].size(); i++) v = v*4 + gq[d][i] + 1;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  initial begin
    int s0, s1, e0, e1, b0, b1;
    fork
      port_driver(0);
      port_driver(1);
      port_driver(2);
      port_driver(3);
    join_none

    repeat (2) @(posedge clk);
    #2;
    check("reset a_rvalid", 64'(t_rv[0]),   64'd0);
    check("reset b_err",    64'(t_err[1]),  64'd0);
    check("reset a_rdata",  64'(t_rd[0]),   64'd0);
    check("reset clr_busy", 64'(t_busy[1]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 1: clear; a B write requested in the clr_start cycle must wait
    b0 = busy_cnt[0]; b1 = busy_cnt[1];
    push(1, 1'b1, 3, 16'hBEEF);
    @(posedge clk);
    #2;
    clr_start = 1'b1;
    @(posedge clk);
    #2;
    clr_start = 1'b0;
    wait_idle();
    check("t1 busy cycles d0", 64'(busy_cnt[0] - b0), 64'd42);
    check("t1 busy cycles d1", 64'(busy_cnt[1] - b1), 64'd42);
    check("t1 taps d0", t_taps[0], 64'hBEEF_0000_0000_0000);

    // 2: write then read word 2 on A
    push(0, 1'b1, 2, 16'h1234);
    push(0, 1'b0, 2, 16'h0000);
    wait_idle();
    check("t2 a_rdata",   64'(last_rd[0]), 64'h1234);
    check("t2 taps word2", 64'(t_taps[0][47:32]), 64'h1234);

    // 3: contention right after an A grant
    s0 = gq[0].size(); s1 = gq[1].size();
    push(0, 1'b0, 4, 16'h0000);
    push(1, 1'b0, 5, 16'h0000);
    wait_idle();
    check("t3 order fixed A,B", 64'(seq_code(0, s0)), 64'd6);
    check("t3 order rr B,A",    64'(seq_code(1, s1)), 64'd9);

    // 4: solo B grant, then both hold req across two jobs each
    push(1, 1'b1, 6, 16'h0606);
    wait_idle();
    s0 = gq[0].size(); s1 = gq[1].size();
    push(0, 1'b0, 2, 16'h0000);
    push(0, 1'b0, 3, 16'h0000);
    push(1, 1'b0, 2, 16'h0000);
    push(1, 1'b0, 3, 16'h0000);
    wait_idle();
    check("t4 order fixed A,A,B,B", 64'(seq_code(0, s0)), 64'h5A);
    check("t4 order rr A,B,A,B",    64'(seq_code(1, s1)), 64'h66);
    check("t4 b_rdata word3",       64'(last_rd[3]), 64'hBEEF);

    // 5: out-of-range read on B, out-of-range write on A
    e0 = err_cnt[1]; e1 = err_cnt[3];
    push(1, 1'b0, 50, 16'h0000);
    wait_idle();
    check("t5 b_err d0",   64'(err_cnt[1] - e0), 64'd1);
    check("t5 b_err d1",   64'(err_cnt[3] - e1), 64'd1);
    check("t5 b_rdata d0", 64'(last_rd[1]), 64'h0000);
    e0 = err_cnt[0];
    push(0, 1'b1, 45, 16'hFFFF);
    wait_idle();
    check("t5 a_err d0", 64'(err_cnt[0] - e0), 64'd1);

    // 6: fill, start clear, reset after ten clear edges
    for (int w = 0; w < DEPTH; w++) push(0, 1'b1, w, 16'hFFFF);
    wait_idle();
    clr_start = 1'b1;
    @(posedge clk);
    #2;
    clr_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("t6 busy before abort", 64'(t_busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6 busy after abort d0", 64'(t_busy[0]), 64'd0);
    check("t6 busy after abort d1", 64'(t_busy[1]), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("t6 taps cleared", t_taps[0], 64'h0);
    s0 = gq[0].size();
    push(0, 1'b0, 9, 16'h0000);
    wait_idle();
    check("t6 a granted after reset", 64'(gq[0].size() - s0), 64'd1);
    check("t6 word9",  64'(last_rd[0]), 64'h0000);
    push(0, 1'b0, 10, 16'h0000);
    wait_idle();
    check("t6 word10", 64'(last_rd[0]), 64'hFFFF);
    for (int w = 0; w < DEPTH; w++) push(0, 1'b0, w, 16'h0000);
    wait_idle();
    check("t6 word41 d1", 64'(last_rd[2]), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
